// File: rtl/cnt_iter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cnt_iter_pkg : shared types and sizing helpers for the count unit     |
// | Revision     : 1.0                                                    |
// +----------------------------------------------------------------------+
package cnt_iter_pkg;

    typedef enum logic [1:0] {
        CNT_CLZ  = 2'b00,
        CNT_CTZ  = 2'b01,
        CNT_CPOP = 2'b10
    } cnt_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } cnt_state_t;

    function automatic int nch_max(input int width, input int chunk);
        return width / chunk;
    endfunction

    function automatic int cnt_width(input int width, input int chunk);
        return $clog2(width / chunk) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cnt_chunk.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cnt_chunk : popcount, leading-zero count and zero flag of one chunk   |
// | Revision  : 1.0                                                       |
// +----------------------------------------------------------------------+
module cnt_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0]       chunk,
    output logic [$clog2(CHUNK):0] popcnt,
    output logic [$clog2(CHUNK):0] lzc,
    output logic                   zero
);
    localparam int c_cw = $clog2(CHUNK) + 1;

    logic w_found;

    always_comb begin
        popcnt  = '0;
        lzc     = '0;
        w_found = 1'b0;
        for (int i = CHUNK - 1; i >= 0; i--) begin
            popcnt = popcnt + c_cw'(chunk[i]);
            if (!w_found) begin
                if (chunk[i]) w_found = 1'b1;
                else          lzc = lzc + c_cw'(1);
            end
        end
        zero = ~|chunk;
    end

endmodule
`default_nettype wire

// File: rtl/cnt_iter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cnt_iter : multi-cycle clz/ctz/cpop, CHUNK bits scanned per cycle     |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
module cnt_iter
    import cnt_iter_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic             Flush,
    input  logic [WIDTH-1:0] A,
    input  logic [1:0]       Op,
    input  logic             W64,
    output logic             Ready,
    output logic             Done,
    output logic [WIDTH-1:0] Result
);
    localparam int c_nch_max = nch_max(WIDTH, CHUNK);
    localparam int c_cntw    = cnt_width(WIDTH, CHUNK);
    localparam int c_rw      = $clog2(WIDTH) + 1;
    localparam int c_cw      = $clog2(CHUNK) + 1;
    localparam logic [WIDTH-1:0] c_lomask = WIDTH'(32'hFFFF_FFFF);

    cnt_state_t        r_state, w_next;
    cnt_op_t           r_op, w_op_in;
    logic [WIDTH-1:0]  r_sh, r_result;
    logic [c_rw-1:0]   r_acc, w_sum;
    logic [c_cntw-1:0] r_cnt, r_nch;

    logic              w_w, w_accept, w_last_chunk, w_final, w_zero;
    logic [WIDTH-1:0]  w_src, w_rev, w_load;
    logic [c_cw-1:0]   w_pop, w_lzc, w_add;
    logic [CHUNK-1:0]  w_chunk;

    assign w_w      = W64 && (WIDTH == 64);
    assign w_accept = (r_state == IDLE) && Start && !Flush;

    always_comb begin
        case (Op)
            2'b00:   w_op_in = CNT_CLZ;
            2'b01:   w_op_in = CNT_CTZ;
            default: w_op_in = CNT_CPOP;
        endcase
    end

    // Word ops scan the low word from the top of the register, so NCH halves.
    assign w_src = w_w ? (A & c_lomask) : A;
    always_comb begin
        w_rev = '0;
        for (int i = 0; i < WIDTH; i++) w_rev[i] = w_src[WIDTH-1-i];
    end
    assign w_load = (w_op_in == CNT_CTZ) ? w_rev :
                    (w_w ? (w_src << (WIDTH - 32)) : w_src);

    assign w_chunk = r_sh[WIDTH-1 -: CHUNK];

    cnt_chunk #(.CHUNK(CHUNK)) u_chunk (
        .chunk  (w_chunk),
        .popcnt (w_pop),
        .lzc    (w_lzc),
        .zero   (w_zero)
    );

    // An all-zero chunk yields lzc == CHUNK, so clz/ctz always add lzc.
    assign w_add        = (r_op == CNT_CPOP) ? w_pop : w_lzc;
    assign w_sum        = r_acc + c_rw'(w_add);
    assign w_last_chunk = (r_cnt == r_nch - c_cntw'(1));
    assign w_final      = (r_state == RUN) &&
                          ((r_op == CNT_CPOP) ? w_last_chunk : (!w_zero || w_last_chunk));

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (Start) w_next = RUN;
            RUN:     if (w_final) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (Flush) w_next = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sh     <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_nch    <= '0;
            r_op     <= CNT_CLZ;
            r_result <= '0;
        end else if (w_accept) begin
            r_sh  <= w_load;
            r_acc <= '0;
            r_cnt <= '0;
            r_nch <= w_w ? c_cntw'(32 / CHUNK) : c_cntw'(c_nch_max);
            r_op  <= w_op_in;
        end else if ((r_state == RUN) && !Flush) begin
            r_sh  <= r_sh << CHUNK;
            r_acc <= w_sum;
            r_cnt <= r_cnt + c_cntw'(1);
            if (w_final) r_result <= WIDTH'(w_sum);
        end
    end

    assign Ready  = (r_state == IDLE);
    assign Done   = (r_state == DONE);
    assign Result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_cnt_iter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_cnt_iter : scoreboard bench for cnt_iter (WIDTH=64, CHUNK=8)       |
// | Revision    : 1.0                                                     |
// +----------------------------------------------------------------------+
module tb_cnt_iter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        Start = 1'b0;
    logic        Flush = 1'b0;
    logic [63:0] A = '0;
    logic [1:0]  Op = 2'b00;
    logic        W64 = 1'b0;
    logic        Ready, Done;
    logic [63:0] Result;

    cnt_iter #(.WIDTH(64), .CHUNK(8)) dut (
        .clk(clk), .reset(reset), .Start(Start), .Flush(Flush), .A(A),
        .Op(Op), .W64(W64), .Ready(Ready), .Done(Done), .Result(Result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] res;
        int          acc;
        int          lat;
    } exp_t;
    exp_t q[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", name, act, act, expv, expv);
        end
    endtask

    // Monitor: every Done pops one expectation; the following cycle must be Ready.
    logic chk_ready = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (chk_ready) check("ready_after_done", {63'd0, Ready}, 64'd1);
        chk_ready = 1'b0;
        if (Done) begin
            if (q.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = q.pop_front();
                check("result", Result, e.res);
                check("latency", 64'(cyc - e.acc), 64'(e.lat));
                chk_ready = 1'b1;
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!Ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!Ready) check("ready_timeout", 64'd0, 64'd1);
    endtask

    // Drives Start for one edge; returns with the DUT past its accept edge.
    task automatic start_op(input logic [1:0] op, input logic w, input logic [63:0] a);
        wait_ready();
        A = a; Op = op; W64 = w; Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
        A = 64'hDEAD_BEEF_CAFE_F00D; Op = 2'b01; W64 = ~w;
    endtask

    task automatic run_op(input logic [1:0] op, input logic w, input logic [63:0] a,
                          input logic [63:0] res, input int lat);
        exp_t e;
        e.acc = cyc + 1;
        e.res = res;
        e.lat = lat;
        q.push_back(e);
        start_op(op, w, a);
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || !Ready) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (q.size() != 0) begin
            check("done_timeout", 64'(q.size()), 64'd0);
            q.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #1;
        check("rst_ready",  {63'd0, Ready}, 64'd1);
        check("rst_done",   {63'd0, Done},  64'd0);
        check("rst_result", Result,         64'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;

        // 1: cpop
        run_op(2'b10, 1'b0, 64'hFFFF_0000_0000_00FF, 64'd24, 8); drain();
        // 2: clz early exit, all-zero, lowest bit
        run_op(2'b00, 1'b0, 64'h0000_0010_0000_0000, 64'd27, 4); drain();
        run_op(2'b00, 1'b0, 64'h0, 64'd64, 8); drain();
        run_op(2'b00, 1'b0, 64'h1, 64'd63, 8); drain();
        // 3: ctz word
        run_op(2'b01, 1'b1, 64'hFFFF_FFFF_0000_0000, 64'd32, 4); drain();
        run_op(2'b01, 1'b1, 64'h0000_0000_0000_0100, 64'd8, 2); drain();
        // clz with top bit set completes in the earliest possible cycle
        run_op(2'b00, 1'b0, 64'h8000_0000_0000_0000, 64'd0, 1); drain();
        // 4: Start during RUN ignored
        run_op(2'b10, 1'b0, 64'h0000_0000_0000_000F, 64'd4, 8);
        @(posedge clk); #1;
        A = 64'hFFFF_FFFF_FFFF_FFFF; Op = 2'b00; Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
        drain();
        // reserved op executes as cpop; leaves Result=24
        run_op(2'b11, 1'b0, 64'hFFFF_0000_0000_00FF, 64'd24, 8); drain();
        // Start with Flush in IDLE: no accept
        Start = 1'b1; Flush = 1'b1; A = 64'h1; Op = 2'b10; W64 = 1'b0;
        @(posedge clk); #1;
        Start = 1'b0; Flush = 1'b0;
        check("flush_start_ready", {63'd0, Ready}, 64'd1);
        // 5: flush at the 3rd RUN edge
        start_op(2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
        repeat (2) begin @(posedge clk); #1; end
        Flush = 1'b1;
        @(posedge clk); #1;
        Flush = 1'b0;
        check("flush_ready",  {63'd0, Ready}, 64'd1);
        check("flush_result", Result,         64'd24);
        repeat (10) @(posedge clk);
        #1;
        check("flush_result_hold", Result, 64'd24);
        run_op(2'b10, 1'b0, 64'h0000_0000_FFFF_FFFF, 64'd32, 8); drain();
        // 6: async reset mid-RUN
        start_op(2'b10, 1'b0, 64'hFFFF_0000_0000_00FF);
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        check("arst_ready",  {63'd0, Ready}, 64'd1);
        check("arst_done",   {63'd0, Done},  64'd0);
        check("arst_result", Result,         64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("arst_idle_result", Result, 64'd0);
        run_op(2'b10, 1'b0, 64'hFFFF_0000_0000_00FF, 64'd24, 8); drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
